// File: rtl/clkdiv_pkg.sv
// Shared types for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned MAX_NCH    = 16;
  localparam int unsigned BITLEN_DEF = 8;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } clkdiv_mode_e;

  // Channel configuration at the default counter width
  typedef struct packed {
    logic [BITLEN_DEF-1:0] lim;
    clkdiv_mode_e          mode;
  } clkdiv_cfg_t;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: wrap counter, shadow/active configuration, pending flag
// and registered hz/tick outputs. Shadow config is applied only at terminal count.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned BITLEN = BITLEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [BITLEN-1:0] cfg_lim,
  input  logic              cfg_mode,
  output logic              hz,
  output logic              tick,
  output logic              pending
);

  typedef struct packed {
    logic [BITLEN-1:0] lim;
    clkdiv_mode_e      mode;
  } cfg_t;

  logic [BITLEN-1:0] q;
  logic [BITLEN-1:0] q_nxt;
  cfg_t              act;
  cfg_t              act_nxt;
  cfg_t              shd;
  cfg_t              shd_nxt;
  cfg_t              wr_cfg;
  cfg_t              apply_cfg;
  logic              hz_nxt;
  logic              tick_nxt;
  logic              pending_nxt;
  logic              terminal;

  assign wr_cfg    = '{lim: cfg_lim, mode: clkdiv_mode_e'(cfg_mode)};
  assign terminal  = (q == act.lim);
  // A write in the same cycle beats any older shadow
  assign apply_cfg = cfg_we ? wr_cfg : (pending ? shd : act);

  always_comb begin
    q_nxt       = q;
    act_nxt     = act;
    shd_nxt     = shd;
    pending_nxt = pending;
    hz_nxt      = hz;
    tick_nxt    = 1'b0;

    if (cfg_we) begin
      shd_nxt = wr_cfg;
    end

    if (!en || sync) begin
      q_nxt       = '0;
      hz_nxt      = 1'b0;
      act_nxt     = apply_cfg;
      pending_nxt = 1'b0;
    end else if (terminal) begin
      q_nxt       = '0;
      tick_nxt    = 1'b1;
      act_nxt     = apply_cfg;
      pending_nxt = 1'b0;
      // A mode switch restarts the output from low
      if (apply_cfg.mode != act.mode) begin
        hz_nxt = 1'b0;
      end else if (act.mode == MODE_PULSE) begin
        hz_nxt = 1'b1;
      end else begin
        hz_nxt = ~hz;
      end
    end else begin
      q_nxt = q + BITLEN'(1);
      if (act.mode == MODE_PULSE) begin
        hz_nxt = 1'b0;
      end
      if (cfg_we) begin
        pending_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      act     <= '{lim: '0, mode: MODE_TOGGLE};
      shd     <= '{lim: '0, mode: MODE_TOGGLE};
      pending <= 1'b0;
      hz      <= 1'b0;
      tick    <= 1'b0;
    end else begin
      q       <= q_nxt;
      act     <= act_nxt;
      shd     <= shd_nxt;
      pending <= pending_nxt;
      hz      <= hz_nxt;
      tick    <= tick_nxt;
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// NCH independent programmable clock-enable dividers sharing one clock.
// Optional CLKDIV_SYNC_EN adds sync_i to phase-align all enabled channels.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned BITLEN = BITLEN_DEF,
  parameter int unsigned NCH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_i,
`endif
  input  logic [NCH-1:0]    en,
  input  logic [NCH-1:0]    cfg_we,
  input  logic [BITLEN-1:0] cfg_lim,
  input  logic              cfg_mode,
  output logic [NCH-1:0]    hzX,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    pending
);

  logic sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clkdiv_chan #(
      .BITLEN (BITLEN)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[i]),
      .sync     (sync),
      .cfg_we   (cfg_we[i]),
      .cfg_lim  (cfg_lim),
      .cfg_mode (cfg_mode),
      .hz       (hzX[i]),
      .tick     (tick[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi (4 channels, 8-bit limits).
// Sync scenario runs only when CLKDIV_SYNC_EN is defined.
module tb_clkdiv_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] en;
  logic [3:0] cfg_we;
  logic [7:0] cfg_lim;
  logic       cfg_mode;
  logic [3:0] hzX;
  logic [3:0] tick;
  logic [3:0] pending;
`ifdef CLKDIV_SYNC_EN
  logic       sync_i;
`endif

  int errors = 0;
  int checks = 0;

  clkdiv_multi #(.BITLEN(8), .NCH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef CLKDIV_SYNC_EN
    .sync_i   (sync_i),
`endif
    .en       (en),
    .cfg_we   (cfg_we),
    .cfg_lim  (cfg_lim),
    .cfg_mode (cfg_mode),
    .hzX      (hzX),
    .tick     (tick),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = '0;
    cfg_we   = '0;
    cfg_lim  = '0;
    cfg_mode = 1'b0;
`ifdef CLKDIV_SYNC_EN
    sync_i   = 1'b0;
`endif
    step(2);
    check_eq("rst_hz", 32'(hzX), 32'h0);
    check_eq("rst_tick", 32'(tick), 32'h0);
    check_eq("rst_pend", 32'(pending), 32'h0);
    rst_n = 1'b1;
    step();

    // Channel 0 at default lim 0: clk/2 and a permanent tick
    en = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_eq("t1_hz0", 32'(hzX[0]), 32'(k % 2));
      check_eq("t1_tick0", 32'(tick[0]), 32'h1);
      check_eq("t1_hz_others", 32'(hzX[3:1]), 32'h0);
    end

    // Channel 1: config written while disabled goes straight to active
    cfg_we = 4'b0010; cfg_lim = 8'd3; cfg_mode = 1'b0;
    step();
    cfg_we = '0;
    check_eq("t2_pend_wr", 32'(pending[1]), 32'h0);
    en = 4'b0011;
    for (int k = 1; k <= 16; k++) begin
      step();
      check_eq("t2_tick1", 32'(tick[1]), 32'(k % 4 == 0));
      check_eq("t2_hz1", 32'(hzX[1]), 32'((k / 4) % 2));
      check_eq("t2_pend1", 32'(pending[1]), 32'h0);
    end

    // Channel 2: lim 9, lower to 2 mid-count; applies at the next wrap
    cfg_we = 4'b0100; cfg_lim = 8'd9; cfg_mode = 1'b0;
    step();
    cfg_we = '0;
    en = 4'b0111;
    for (int k = 1; k <= 19; k++) begin
      if (k == 5) begin
        cfg_we = 4'b0100; cfg_lim = 8'd2; cfg_mode = 1'b0;
      end
      step();
      cfg_we = '0;
      check_eq("t3_pend2", 32'(pending[2]), 32'(k >= 5 && k <= 9));
      check_eq("t3_tick2", 32'(tick[2]), 32'(k == 10 || k == 13 || k == 16 || k == 19));
      check_eq("t3_hz2", 32'(hzX[2]), 32'(k >= 10 && ((k - 10) / 3) % 2 == 0));
    end

    // Channel 3: write pulse mode lim 4 exactly on a terminal-count cycle
    cfg_we = 4'b1000; cfg_lim = 8'd2; cfg_mode = 1'b0;
    step();
    cfg_we = '0;
    en = 4'b1111;
    for (int k = 1; k <= 18; k++) begin
      if (k == 3) begin
        cfg_we = 4'b1000; cfg_lim = 8'd4; cfg_mode = 1'b1;
      end
      step();
      cfg_we = '0;
      cfg_mode = 1'b0;
      check_eq("t4_tick3", 32'(tick[3]), 32'(k == 3 || (k >= 8 && (k - 3) % 5 == 0)));
      check_eq("t4_hz3", 32'(hzX[3]), 32'(k >= 8 && (k - 3) % 5 == 0));
      check_eq("t4_pend3", 32'(pending[3]), 32'h0);
    end

    // All channels lim 200, then async reset mid-count
    en = '0;
    cfg_we = 4'b1111; cfg_lim = 8'd200; cfg_mode = 1'b0;
    step();
    cfg_we = '0;
    en = 4'b1111;
    step(205);
    check_eq("t5_hz_pre", 32'(hzX), 32'hf);
    check_eq("t5_tick_pre", 32'(tick), 32'h0);
    cfg_we = 4'b0001; cfg_lim = 8'd100;
    step();
    cfg_we = '0;
    check_eq("t5_pend_pre", 32'(pending), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t5_hz_rst", 32'(hzX), 32'h0);
    check_eq("t5_tick_rst", 32'(tick), 32'h0);
    check_eq("t5_pend_rst", 32'(pending), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("t5_tick_r1", 32'(tick), 32'hf);
    check_eq("t5_hz_r1", 32'(hzX), 32'hf);
    step();
    check_eq("t5_tick_r2", 32'(tick), 32'hf);
    check_eq("t5_hz_r2", 32'(hzX), 32'h0);
    check_eq("t5_pend_r2", 32'(pending), 32'h0);

`ifdef CLKDIV_SYNC_EN
    // Lims 2,4,6,8 started out of phase, then aligned by sync_i
    en = '0;
    for (int i = 0; i < 4; i++) begin
      cfg_we = 4'(1 << i); cfg_lim = 8'(2 * i + 2); cfg_mode = 1'b0;
      step();
    end
    cfg_we = '0;
    en = 4'b0001; step(2);
    en = 4'b0011; step(1);
    en = 4'b0111; step(3);
    en = 4'b1111; step(7);
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    check_eq("t6_hz_sync", 32'(hzX), 32'h0);
    check_eq("t6_tick_sync", 32'(tick), 32'h0);
    for (int k = 1; k <= 315; k++) begin
      logic [3:0] exp_tick;
      step();
      for (int i = 0; i < 4; i++) exp_tick[i] = (k % (2 * i + 3) == 0);
      check_eq("t6_tick", 32'(tick), 32'(exp_tick));
    end
    check_eq("t6_hz_lcm", 32'(hzX), 32'hf);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
Parametrised multi-channel successor to the single-channel clock divider. Generates NCH independent divided enables from one clk. Each channel has a runtime-programmable limit and a mode (toggle / pulse), plus a per-channel enable. Limit and mode updates are shadowed and applied glitch-free at the channel's terminal count. Feeds LED blinkers, scan multiplexers and baud/tick consumers.

Parameters:
BITLEN, 8, width of each channel counter and limit
NCH, 4, number of independent channels (1..16)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
en  in  NCH  per-channel run enable (level)
cfg_we  in  NCH  per-channel config write strobe; multiple bits set writes all selected channels
cfg_lim  in  BITLEN  limit written to selected channels
cfg_mode  in  1  mode written to selected channels: 0 = toggle, 1 = pulse
hzX  out  NCH  divided output per channel
tick  out  NCH  one-cycle strobe per channel at terminal count
pending  out  NCH  1 = shadow config not yet applied

Behaviour:
- Reset (rst_n low, async): all counters 0; active lim 0; active mode toggle; shadows cleared; hzX, tick and pending all 0.
- Per channel i: counter Q, active lim/mode, shadow lim/mode, pending flag. Channels are fully independent.
- Enabled and Q != lim: Q <= Q+1; tick[i] <= 0; hzX holds in toggle mode and is 0 in pulse mode.
- Enabled and Q == lim (terminal):
  - Q <= 0; tick[i] <= 1.
  - Toggle mode: hzX[i] <= ~hzX[i].
  - Pulse mode: hzX[i] <= 1 for that one cycle.
- Outputs are registered. tick/hzX update on the same edge where the counter wraps.
- Periods:
  - Toggle mode: hzX period 2*(lim+1) clk cycles, 50% duty.
  - Pulse mode: period lim+1 clk cycles.
- lim = 0: toggle mode gives clk/2. In pulse mode, tick and hzX are held high continuously.
- Q never exceeds lim. The counter wraps at lim, not at 2^BITLEN-1. lim = 2^BITLEN-1 gives maximum division with no overflow.
- en[i] low:
  - Q held at 0; hzX[i] and tick[i] forced 0 on the next edge.
  - Any pending shadow is applied immediately and pending cleared.
  - On re-enable, counting restarts from 0. The first terminal count occurs after lim+1 cycles.
- cfg_we[i] high:
  - Shadow <= {cfg_lim, cfg_mode}; pending[i] <= 1 on the next edge.
  - If the channel is disabled, the config goes straight to active and pending stays 0.
- Apply rule: at a terminal-count edge with pending set, active <= shadow and pending <= 0. The new lim governs the next count sequence.
- A mode change applied at terminal count forces hzX[i] <= 0 on that edge instead of toggling or pulsing.
- Simultaneous cfg_we[i] and terminal count on channel i: the written value bypasses the shadow into active on that edge; pending stays 0. The written value wins over any older shadow.
- Back-to-back writes before terminal count: last write wins.
- Reset mid-count: immediate return to reset state; no partial tick.

Optional Feature:
CLKDIV_SYNC_EN
- Defined: adds input sync_i (1 bit). While sync_i is high, every enabled channel loads Q <= 0, clears hzX and tick, and applies any pending shadow. All channels are then phase-aligned from the next cycle. sync_i has priority over terminal count and cfg_we bypass; the write still lands in active.
- Undefined: no port; channels are aligned only by reset or by en.

Decomposition:
- Package clkdiv_pkg: typedef enum logic {MODE_TOGGLE, MODE_PULSE} clkdiv_mode_e; typedef struct packed {lim, mode} clkdiv_cfg_t, parametrised via BITLEN; localparam MAX_NCH = 16.
- Sub-module clkdiv_chan: one channel (counter, shadow/active cfg, pending, outputs). The top generates NCH instances and fans out cfg_lim/cfg_mode plus the optional sync_i.

Test Plan:
- Reset then en=4'b0001 at lim 0 default → hzX[0] toggles every cycle (clk/2); tick[0] high continuously; channels 1-3 hold hzX=0.
- Write lim=3 to ch1 while disabled, then enable → pending[1] never set; tick[1] every 4 cycles; hzX[1] period 8, 50% duty.
- Ch2 running lim=9 toggle; write lim=2 mid-count at Q=4 → pending[2]=1 until Q reaches 9; after that wrap, tick spacing becomes 3.
- Write cfg_mode=1, lim=4 to ch3 exactly on a terminal-count cycle → applied that edge, pending stays 0, hzX[3] forced 0; then 1-cycle hzX pulses every 5 cycles.
- Drop rst_n mid-count with lim=200 → all outputs 0 asynchronously; after release, first tick on each channel comes after lim+1 cycles, with lim back at 0.
- (CLKDIV_SYNC_EN) Four channels at lims 2, 4, 6, 8 running out of phase; pulse sync_i one cycle → all Q=0 and hzX=0; ticks later coincide at cycle 3·5·7·9 LCM multiples (315).
